csi2_pkt_parser: RTL
====================

// Module: csi2_pkt_parser
// PURPOSE
//  Consumes the 32-bit word stream produced by the D-PHY lane-to-word mapping stage.
//  It splits each HS burst into a CSI-2 packet header, a payload stream and a CRC.
//  Header fields and CRC are exported unchecked; ECC/CRC checking is a later stage.
//  The payload is a registered, stream-style output with byte enables and a last flag.
// PARAMETERS
//  none (word width fixed at 32, byte 0 = first byte on the wire = data_i[7:0])
// PORTS
//  byte_clk_i      in   1   byte clock; all logic on rising edge
//  rst_n_i         in   1   asynchronous active-low reset
//  data_i          in   32  mapped word from lane mapper
//  valid_i         in   1   data_i valid this cycle
//  eop_i           in   1   end of HS burst; data_i ignored in an eop_i cycle
//  hdr_valid_o     out  1   1-cycle pulse: header fields below updated
//  vc_o            out  2   virtual channel = header byte0[7:6]
//  dt_o            out  6   data type = header byte0[5:0]
//  word_cnt_o      out  16  {byte2, byte1} of header
//  ecc_o           out  8   header byte3, raw
//  short_pkt_o     out  1   dt_o < 6'h10 (short packet, no payload/CRC)
//  tdata_o         out  32  payload word, byte0 in [7:0]
//  tvalid_o        out  1   payload word valid (no backpressure; no ready input)
//  tkeep_o         out  4   byte enables; 4'hF except on the last word
//  tlast_o         out  1   last payload word of packet
//  crc_o           out  16  {second CRC byte, first CRC byte}
//  crc_valid_o     out  1   1-cycle pulse: crc_o updated
//  trunc_o         out  1   1-cycle pulse: eop_i before CRC fully received
// BEHAVIOUR
//  Reset (async): every output 0; FSM in IDLE; bytes_left is 0.
//  FSM states: IDLE, PAYLOAD, CRC_WAIT, DISCARD. An eop_i cycle forces IDLE from any state.
//   IDLE: first valid_i word is the header.
//    - Latch the header fields; pulse hdr_valid_o next cycle.
//    - If short_pkt, go to DISCARD.
//    - If long packet, load bytes_left = WC.
//    - If WC==0, go to CRC_WAIT with crc_off = 0; otherwise go to PAYLOAD.
//   PAYLOAD: on each valid_i word, the word appears on tdata_o with tvalid_o=1 one cycle later.
//    - If bytes_left > 4: tkeep 4'hF, tlast 0, bytes_left -= 4.
//    - Else (final word, r = bytes_left in 1..4): tkeep = (1<<r)-1, tlast 1.
//    - On the final word, r = WC%4 selects the CRC position:
//      r=1 -> CRC bytes 1,2 of this word -> crc_valid next cycle, go to DISCARD.
//      r=2 -> CRC bytes 2,3 of this word -> crc_valid next cycle, go to DISCARD.
//      r=3 -> byte 3 is CRC low; hold it, go to CRC_WAIT with crc_off = 3.
//      r=4 -> go to CRC_WAIT with crc_off = 0.
//   CRC_WAIT: next valid word supplies the CRC, then pulse crc_valid_o and go to DISCARD.
//    - crc_off = 0: CRC = {byte1, byte0}.
//    - crc_off = 3: CRC = {byte0, held byte}.
//   DISCARD: ignore words until eop_i. One packet per HS burst.
//  Latency: exactly 1 cycle from input word to hdr_valid/tvalid/crc_valid outputs.
//  tvalid_o, hdr_valid_o and crc_valid_o drop to 0 in every cycle without a qualifying input.
//  Data outputs hold their last value.
//  Truncation: eop_i in PAYLOAD or CRC_WAIT -> trunc_o pulse next cycle.
//   - No tlast is emitted for the truncated packet; FSM goes to IDLE.
//  eop_i and valid_i in the same cycle: the eop wins and the word is dropped.
//  valid_i gaps inside a packet: state and counters hold.
//  WC up to 16'hFFFF: bytes_left is 16 bits, no wrap.
// TESTING
//  1 Short pkt: word 32'h2B_0001_00 -> hdr_valid=1, dt=0, vc=0, word_cnt=16'h0001, short=1.
//    No tvalid, no crc_valid.
//  2 Long pkt, WC=8: header 32'h12_0008_2A, payload words W0, W1, then 32'h0000_BEEF.
//    -> tvalid on W0 and W1; W1 has tkeep F, tlast=1; crc=16'hBEEF.
//  3 WC=5, CRC straddle: last payload word 32'h00_34_12_AA, then word with byte0=56.
//    -> last word tkeep=4'h1, tlast=1; crc=16'h3412 in the same cycle as tlast.
//  4 WC=7: last word byte3=CD, next word byte0=AB -> tkeep=4'h7; crc=16'hABCD one cycle after tlast.
//  5 Truncation: WC=16, eop_i after 2 payload words.
//    -> trunc_o pulse, no tlast; the next burst's header parses normally.
//  6 rst_n_i low mid-payload, async -> all outputs 0 immediately; after release, a fresh header parses.
//    Also: valid_i gaps of 3 cycles mid-payload -> output identical except timing.

Source files
------------

// File: rtl/csi2_pkt_parser_if.sv
// Word stream from the lane mapper into the CSI-2 packet parser, plus the parsed
// header, payload stream and CRC results coming out of it.
interface csi2_pkt_parser_if;
    logic [31:0] data_i;
    logic        valid_i;
    logic        eop_i;

    logic        hdr_valid_o;
    logic [1:0]  vc_o;
    logic [5:0]  dt_o;
    logic [15:0] word_cnt_o;
    logic [7:0]  ecc_o;
    logic        short_pkt_o;

    logic [31:0] tdata_o;
    logic        tvalid_o;
    logic [3:0]  tkeep_o;
    logic        tlast_o;

    logic [15:0] crc_o;
    logic        crc_valid_o;
    logic        trunc_o;

    modport master (
        output data_i, valid_i, eop_i,
        input  hdr_valid_o, vc_o, dt_o, word_cnt_o, ecc_o, short_pkt_o,
        input  tdata_o, tvalid_o, tkeep_o, tlast_o,
        input  crc_o, crc_valid_o, trunc_o
    );

    modport slave (
        input  data_i, valid_i, eop_i,
        output hdr_valid_o, vc_o, dt_o, word_cnt_o, ecc_o, short_pkt_o,
        output tdata_o, tvalid_o, tkeep_o, tlast_o,
        output crc_o, crc_valid_o, trunc_o
    );
endinterface

// File: rtl/csi2_pkt_parser.sv
// Splits one HS burst into CSI-2 header, payload stream and raw CRC; every output is 1 cycle after its word.
// No backpressure: the payload stream has no ready, input gaps simply stall the parser.
module csi2_pkt_parser (
    input  logic              byte_clk_i,
    input  logic              rst_n_i,
    csi2_pkt_parser_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_WAIT, DISCARD} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_bytes_left, w_bytes_left_nxt;
    logic        r_crc_off3, w_crc_off3_nxt;
    logic [7:0]  r_crc_lo, w_crc_lo_nxt;

    logic        r_hdr_vld, w_hdr_vld;
    logic [1:0]  r_vc, w_vc;
    logic [5:0]  r_dt, w_dt;
    logic [15:0] r_wc, w_wc;
    logic [7:0]  r_ecc, w_ecc;
    logic        r_short, w_short;
    logic [31:0] r_tdata, w_tdata;
    logic        r_tvalid, w_tvalid;
    logic [3:0]  r_tkeep, w_tkeep;
    logic        r_tlast, w_tlast;
    logic [15:0] r_crc, w_crc;
    logic        r_crc_vld, w_crc_vld;
    logic        r_trunc, w_trunc;

    logic        w_hdr_short;
    logic        w_final;
    logic [3:0]  w_keep_final;

    // An eop cycle never carries a usable word.
    assign w_hdr_short = (bus.data_i[5:0] < 6'h10);
    assign w_final     = (r_bytes_left <= 16'd4);

    always_comb begin
        w_keep_final = 4'hF;
        case (r_bytes_left[2:0])
            3'd1:    w_keep_final = 4'h1;
            3'd2:    w_keep_final = 4'h3;
            3'd3:    w_keep_final = 4'h7;
            default: w_keep_final = 4'hF;
        endcase
    end

    always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_bytes_left <= 16'd0;
            r_crc_off3   <= 1'b0;
            r_crc_lo     <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bytes_left <= w_bytes_left_nxt;
            r_crc_off3   <= w_crc_off3_nxt;
            r_crc_lo     <= w_crc_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bytes_left_nxt = r_bytes_left;
        w_crc_off3_nxt   = r_crc_off3;
        w_crc_lo_nxt     = r_crc_lo;
        if (bus.eop_i) begin
            w_state_nxt = IDLE;
        end else if (bus.valid_i) begin
            case (r_state)
                IDLE: begin
                    if (w_hdr_short) begin
                        w_state_nxt = DISCARD;
                    end else begin
                        w_bytes_left_nxt = bus.data_i[23:8];
                        w_crc_off3_nxt   = 1'b0;
                        w_state_nxt      = (bus.data_i[23:8] == 16'd0) ? CRC_WAIT : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!w_final) begin
                        w_bytes_left_nxt = r_bytes_left - 16'd4;
                    end else begin
                        w_bytes_left_nxt = 16'd0;
                        case (r_bytes_left[2:0])
                            3'd1, 3'd2: w_state_nxt = DISCARD;
                            3'd3: begin
                                w_state_nxt    = CRC_WAIT;
                                w_crc_off3_nxt = 1'b1;
                                w_crc_lo_nxt   = bus.data_i[31:24];
                            end
                            default: begin
                                w_state_nxt    = CRC_WAIT;
                                w_crc_off3_nxt = 1'b0;
                            end
                        endcase
                    end
                end
                CRC_WAIT: w_state_nxt = DISCARD;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_hdr_vld = 1'b0;
        w_tvalid  = 1'b0;
        w_crc_vld = 1'b0;
        w_trunc   = 1'b0;
        w_vc      = r_vc;
        w_dt      = r_dt;
        w_wc      = r_wc;
        w_ecc     = r_ecc;
        w_short   = r_short;
        w_tdata   = r_tdata;
        w_tkeep   = r_tkeep;
        w_tlast   = r_tlast;
        w_crc     = r_crc;
        if (bus.eop_i) begin
            w_trunc = (r_state == PAYLOAD) || (r_state == CRC_WAIT);
        end else if (bus.valid_i) begin
            case (r_state)
                IDLE: begin
                    w_hdr_vld = 1'b1;
                    w_vc      = bus.data_i[7:6];
                    w_dt      = bus.data_i[5:0];
                    w_wc      = bus.data_i[23:8];
                    w_ecc     = bus.data_i[31:24];
                    w_short   = w_hdr_short;
                end
                PAYLOAD: begin
                    w_tvalid = 1'b1;
                    w_tdata  = bus.data_i;
                    w_tkeep  = w_final ? w_keep_final : 4'hF;
                    w_tlast  = w_final;
                    // CRC fully inside the final word when 1 or 2 payload bytes remain.
                    if (w_final && (r_bytes_left[2:0] == 3'd1)) begin
                        w_crc     = bus.data_i[23:8];
                        w_crc_vld = 1'b1;
                    end else if (w_final && (r_bytes_left[2:0] == 3'd2)) begin
                        w_crc     = bus.data_i[31:16];
                        w_crc_vld = 1'b1;
                    end
                end
                CRC_WAIT: begin
                    w_crc_vld = 1'b1;
                    w_crc     = r_crc_off3 ? {bus.data_i[7:0], r_crc_lo} : bus.data_i[15:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hdr_vld <= 1'b0;
            r_vc      <= 2'd0;
            r_dt      <= 6'd0;
            r_wc      <= 16'd0;
            r_ecc     <= 8'd0;
            r_short   <= 1'b0;
            r_tdata   <= 32'd0;
            r_tvalid  <= 1'b0;
            r_tkeep   <= 4'd0;
            r_tlast   <= 1'b0;
            r_crc     <= 16'd0;
            r_crc_vld <= 1'b0;
            r_trunc   <= 1'b0;
        end else begin
            r_hdr_vld <= w_hdr_vld;
            r_vc      <= w_vc;
            r_dt      <= w_dt;
            r_wc      <= w_wc;
            r_ecc     <= w_ecc;
            r_short   <= w_short;
            r_tdata   <= w_tdata;
            r_tvalid  <= w_tvalid;
            r_tkeep   <= w_tkeep;
            r_tlast   <= w_tlast;
            r_crc     <= w_crc;
            r_crc_vld <= w_crc_vld;
            r_trunc   <= w_trunc;
        end
    end

    assign bus.hdr_valid_o = r_hdr_vld;
    assign bus.vc_o        = r_vc;
    assign bus.dt_o        = r_dt;
    assign bus.word_cnt_o  = r_wc;
    assign bus.ecc_o       = r_ecc;
    assign bus.short_pkt_o = r_short;
    assign bus.tdata_o     = r_tdata;
    assign bus.tvalid_o    = r_tvalid;
    assign bus.tkeep_o     = r_tkeep;
    assign bus.tlast_o     = r_tlast;
    assign bus.crc_o       = r_crc;
    assign bus.crc_valid_o = r_crc_vld;
    assign bus.trunc_o     = r_trunc;

endmodule
